stack_sequencer: RTL and testbench

- Micro-sequencer for PUSH, POP, CALL and RET on the CPU datapath.
- The control unit hands it one stack operation. It then drives, one step at a time, the stack pointer, the memory address register, memory read/write, the PC load/output and the register-file enables on the shared 8-bit bus.
- It sits beside the control unit. While busy it owns the sp_*, mar_en, pc_* and reg_* strobes; the CPU ORs its strobes into the existing c_* nets.

---
 rtl/stack_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: step-paced micro-sequencer for PUSH/POP/CALL/RET.
// Drives SP, MAR, memory, PC and register-file strobes one machine cycle at a
// time. Optional overflow/underflow guard: define STACK_SEQUENCER_GUARD_EN.
// All strobes are registered and always match the decode of the current state.
module stack_sequencer #(
  parameter logic [7:0] STACK_BASE  = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hF0,
  localparam int unsigned OP_W      = 2,
  localparam int unsigned SEL_W     = 3,
  localparam int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [SEL_W-1:0]  reg_sel_in,
  input  logic [DATA_W-1:0] sp_value,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              sp_en,
  output logic              sp_dec,
  output logic              sp_out,
  output logic              mar_en,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              pc_en,
  output logic              pc_wr,
  output logic              pc_out,
  output logic              tgt_out,
  output logic              reg_in,
  output logic              reg_out,
  output logic [SEL_W-1:0]  reg_sel
);

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR  = 3'd1;
  localparam logic [STATE_W-1:0] S_WRITE = 3'd2;
  localparam logic [STATE_W-1:0] S_DEC   = 3'd3;
  localparam logic [STATE_W-1:0] S_INC   = 3'd4;
  localparam logic [STATE_W-1:0] S_READ  = 3'd5;
  localparam logic [STATE_W-1:0] S_JUMP  = 3'd6;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd7;

  localparam logic [OP_W-1:0] OP_PUSH = 2'b00;
  localparam logic [OP_W-1:0] OP_POP  = 2'b01;
  localparam logic [OP_W-1:0] OP_CALL = 2'b10;
  localparam logic [OP_W-1:0] OP_RET  = 2'b11;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_n;
  logic [OP_W-1:0]    op_q;
  logic [OP_W-1:0]    op_n;
  logic [SEL_W-1:0]   reg_sel_n;
  logic               flag_q;
  logic               flag_n;
  logic               guard_fail_c;

  logic busy_n, done_n, fault_n;
  logic sp_en_n, sp_dec_n, sp_out_n, mar_en_n;
  logic mem_wr_n, mem_rd_n;
  logic pc_en_n, pc_wr_n, pc_out_n, tgt_out_n;
  logic reg_in_n, reg_out_n;

`ifdef STACK_SEQUENCER_GUARD_EN
  // Refuse a push into a full stack or a pop from an empty one.
  always_comb begin
    guard_fail_c = 1'b0;
    case (op)
      OP_PUSH, OP_CALL: guard_fail_c = (sp_value == STACK_LIMIT);
      OP_POP,  OP_RET:  guard_fail_c = (sp_value == STACK_BASE);
      default:          guard_fail_c = 1'b0;
    endcase
  end
`else
  // Without the guard the SP simply wraps; the pointer is not inspected.
  logic unused_guard_inputs;
  assign unused_guard_inputs = ^{sp_value, STACK_BASE, STACK_LIMIT};
  assign guard_fail_c = 1'b0;
`endif

  // State, latches and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      reg_sel <= '0;
      flag_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      sp_en   <= 1'b0;
      sp_dec  <= 1'b0;
      sp_out  <= 1'b0;
      mar_en  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_rd  <= 1'b0;
      pc_en   <= 1'b0;
      pc_wr   <= 1'b0;
      pc_out  <= 1'b0;
      tgt_out <= 1'b0;
      reg_in  <= 1'b0;
      reg_out <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      reg_sel <= reg_sel_n;
      flag_q  <= flag_n;
      busy    <= busy_n;
      done    <= done_n;
      fault   <= fault_n;
      sp_en   <= sp_en_n;
      sp_dec  <= sp_dec_n;
      sp_out  <= sp_out_n;
      mar_en  <= mar_en_n;
      mem_wr  <= mem_wr_n;
      mem_rd  <= mem_rd_n;
      pc_en   <= pc_en_n;
      pc_wr   <= pc_wr_n;
      pc_out  <= pc_out_n;
      tgt_out <= tgt_out_n;
      reg_in  <= reg_in_n;
      reg_out <= reg_out_n;
    end
  end

  // Next state on step, then Moore decode of the state being entered.
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    reg_sel_n = reg_sel;
    flag_n    = flag_q;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    fault_n   = 1'b0;
    sp_en_n   = 1'b0;
    sp_dec_n  = 1'b0;
    sp_out_n  = 1'b0;
    mar_en_n  = 1'b0;
    mem_wr_n  = 1'b0;
    mem_rd_n  = 1'b0;
    pc_en_n   = 1'b0;
    pc_wr_n   = 1'b0;
    pc_out_n  = 1'b0;
    tgt_out_n = 1'b0;
    reg_in_n  = 1'b0;
    reg_out_n = 1'b0;

    if (step) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_n      = op;
            reg_sel_n = reg_sel_in;
            flag_n    = 1'b0;
            if (guard_fail_c) begin
              state_n = S_DONE;
              flag_n  = 1'b1;
            end else if (op == OP_PUSH || op == OP_CALL) begin
              state_n = S_ADDR;
            end else begin
              state_n = S_INC;
            end
          end
        end
        S_ADDR:  state_n = (op_q == OP_PUSH || op_q == OP_CALL) ? S_WRITE : S_READ;
        S_WRITE: state_n = S_DEC;
        S_DEC:   state_n = (op_q == OP_CALL) ? S_JUMP : S_DONE;
        S_INC:   state_n = S_ADDR;
        S_READ:  state_n = S_DONE;
        S_JUMP:  state_n = S_DONE;
        S_DONE: begin
          state_n = S_IDLE;
          flag_n  = 1'b0;
        end
        default: state_n = S_IDLE;
      endcase
    end

    busy_n = (state_n != S_IDLE);
    case (state_n)
      S_ADDR: begin
        sp_out_n = 1'b1;
        mar_en_n = 1'b1;
      end
      S_WRITE: begin
        mem_wr_n  = 1'b1;
        reg_out_n = (op_n == OP_PUSH);
        pc_out_n  = (op_n == OP_CALL);
      end
      S_DEC: begin
        sp_en_n  = 1'b1;
        sp_dec_n = 1'b1;
      end
      S_INC: begin
        sp_en_n = 1'b1;
      end
      S_READ: begin
        mem_rd_n = 1'b1;
        reg_in_n = (op_n == OP_POP);
        pc_en_n  = (op_n == OP_RET);
        pc_wr_n  = (op_n == OP_RET);
      end
      S_JUMP: begin
        tgt_out_n = 1'b1;
        pc_en_n   = 1'b1;
        pc_wr_n   = 1'b1;
      end
      S_DONE: begin
        done_n  = 1'b1;
        fault_n = flag_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed scoreboard bench for stack_sequencer. Build with
// +define+STACK_SEQUENCER_GUARD_EN to exercise the guarded variant.
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       reset, step, start;
  logic [1:0] op;
  logic [2:0] reg_sel_in;
  logic [7:0] sp_value;
  logic       busy, done, fault, sp_en, sp_dec, sp_out, mar_en, mem_wr, mem_rd;
  logic       pc_en, pc_wr, pc_out, tgt_out, reg_in, reg_out;
  logic [2:0] reg_sel;

  int checks   = 0;
  int failures = 0;

  localparam logic [14:0] M_BUSY    = 15'h4000;
  localparam logic [14:0] M_DONE    = 15'h2000;
  localparam logic [14:0] M_FAULT   = 15'h1000;
  localparam logic [14:0] M_SP_EN   = 15'h0800;
  localparam logic [14:0] M_SP_DEC  = 15'h0400;
  localparam logic [14:0] M_SP_OUT  = 15'h0200;
  localparam logic [14:0] M_MAR_EN  = 15'h0100;
  localparam logic [14:0] M_MEM_WR  = 15'h0080;
  localparam logic [14:0] M_MEM_RD  = 15'h0040;
  localparam logic [14:0] M_PC_EN   = 15'h0020;
  localparam logic [14:0] M_PC_WR   = 15'h0010;
  localparam logic [14:0] M_PC_OUT  = 15'h0008;
  localparam logic [14:0] M_TGT_OUT = 15'h0004;
  localparam logic [14:0] M_REG_IN  = 15'h0002;
  localparam logic [14:0] M_REG_OUT = 15'h0001;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;

  typedef struct packed {
    logic [14:0] vec;
    logic [2:0]  sel;
  } exp_t;

  exp_t sbq[$];

  logic [14:0] obs;
  logic [4:0]  drivers;
  assign obs = {busy, done, fault, sp_en, sp_dec, sp_out, mar_en, mem_wr, mem_rd,
                pc_en, pc_wr, pc_out, tgt_out, reg_in, reg_out};
  assign drivers = {sp_out, mem_rd, pc_out, tgt_out, reg_out};

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .step(step), .start(start), .op(op),
    .reg_sel_in(reg_sel_in), .sp_value(sp_value),
    .busy(busy), .done(done), .fault(fault), .sp_en(sp_en), .sp_dec(sp_dec),
    .sp_out(sp_out), .mar_en(mar_en), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .pc_en(pc_en), .pc_wr(pc_wr), .pc_out(pc_out), .tgt_out(tgt_out),
    .reg_in(reg_in), .reg_out(reg_out), .reg_sel(reg_sel)
  );

  task automatic check_vec(input string tag, input logic [14:0] e_vec, input logic [2:0] e_sel);
    checks++;
    assert (obs === e_vec) else begin
      failures++;
      $error("FAIL %s strobes obs=%h exp=%h", tag, obs, e_vec);
    end
    checks++;
    assert (reg_sel === e_sel) else begin
      failures++;
      $error("FAIL %s reg_sel obs=%0d exp=%0d", tag, reg_sel, e_sel);
    end
    checks++;
    assert ($onehot0(drivers)) else begin
      failures++;
      $error("FAIL %s bus_drivers obs=%b exp=onehot0", tag, drivers);
    end
  endtask

  // One step pulse, then two idle clocks during which outputs must hold.
  task automatic step_check(input string tag, input logic st, input logic [1:0] o, input logic [2:0] rs);
    exp_t e;
    @(negedge clk);
    step = 1'b1; start = st; op = o; reg_sel_in = rs;
    @(negedge clk);
    step = 1'b0; start = 1'b0;
    checks++;
    assert (sbq.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard obs=empty exp=entry", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_vec(tag, e.vec, e.sel);
      repeat (2) begin
        @(negedge clk);
        check_vec({tag, "_hold"}, e.vec, e.sel);
      end
    end
  endtask

  // Reference model: per-step strobe pattern for one operation.
  task automatic expect_op(input logic [1:0] o, input logic [2:0] rs, input logic [7:0] spv);
    bit gf;
    exp_t e;
    gf = 1'b0;
`ifdef STACK_SEQUENCER_GUARD_EN
    if ((o == PUSH || o == CALL) && spv == 8'hF0) gf = 1'b1;
    if ((o == POP  || o == RET)  && spv == 8'hFF) gf = 1'b1;
`endif
    e.sel = rs;
    if (gf) begin
      e.vec = M_BUSY | M_DONE | M_FAULT; sbq.push_back(e);
    end else begin
      case (o)
        PUSH: begin
          e.vec = M_BUSY | M_SP_OUT | M_MAR_EN;  sbq.push_back(e);
          e.vec = M_BUSY | M_MEM_WR | M_REG_OUT; sbq.push_back(e);
          e.vec = M_BUSY | M_SP_EN | M_SP_DEC;   sbq.push_back(e);
        end
        POP: begin
          e.vec = M_BUSY | M_SP_EN;              sbq.push_back(e);
          e.vec = M_BUSY | M_SP_OUT | M_MAR_EN;  sbq.push_back(e);
          e.vec = M_BUSY | M_MEM_RD | M_REG_IN;  sbq.push_back(e);
        end
        CALL: begin
          e.vec = M_BUSY | M_SP_OUT | M_MAR_EN;  sbq.push_back(e);
          e.vec = M_BUSY | M_MEM_WR | M_PC_OUT;  sbq.push_back(e);
          e.vec = M_BUSY | M_SP_EN | M_SP_DEC;   sbq.push_back(e);
          e.vec = M_BUSY | M_TGT_OUT | M_PC_EN | M_PC_WR; sbq.push_back(e);
        end
        default: begin
          e.vec = M_BUSY | M_SP_EN;              sbq.push_back(e);
          e.vec = M_BUSY | M_SP_OUT | M_MAR_EN;  sbq.push_back(e);
          e.vec = M_BUSY | M_MEM_RD | M_PC_EN | M_PC_WR; sbq.push_back(e);
        end
      endcase
      e.vec = M_BUSY | M_DONE; sbq.push_back(e);
    end
    e.vec = '0; sbq.push_back(e);
  endtask

  // Accept one op, then step until the scoreboard drains (bounded).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] rs,
                        input logic [7:0] spv, input bit start_busy);
    sp_value = spv;
    expect_op(o, rs, spv);
    step_check(tag, 1'b1, o, rs);
    for (int i = 0; i < 8 && sbq.size() > 0; i++)
      step_check(tag, start_busy, start_busy ? ~o : o, ~rs);
    checks++;
    assert (sbq.size() == 0) else begin
      failures++;
      $error("FAIL %s drain obs=%0d exp=0", tag, sbq.size());
    end
    sbq.delete();
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; start = 1'b0; op = '0; reg_sel_in = '0; sp_value = 8'hFF;
    repeat (3) @(negedge clk);
    check_vec("reset", '0, '0);
    reset = 1'b0;

    // Idle steps with no request, then a request without step.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      check_vec("idle", '0, '0);
    end
    @(negedge clk); start = 1'b1; op = PUSH; reg_sel_in = 3'd1;
    @(negedge clk); start = 1'b0;
    check_vec("start_no_step", '0, '0);

    run_op("push", PUSH, 3'd3, 8'hFF, 1'b0);
    run_op("pop",  POP,  3'd5, 8'hFE, 1'b0);
    run_op("call", CALL, 3'd2, 8'hFE, 1'b0);
    run_op("ret",  RET,  3'd6, 8'hFD, 1'b0);
    run_op("push_full", PUSH, 3'd2, 8'hF0, 1'b0);
    run_op("pop_empty", POP,  3'd6, 8'hFF, 1'b0);
    run_op("call_full", CALL, 3'd1, 8'hF0, 1'b0);
    run_op("ret_empty", RET,  3'd4, 8'hFF, 1'b0);
    run_op("push_restart", PUSH, 3'd4, 8'hFA, 1'b1);

    // Reset while in WRITE of a CALL.
    sp_value = 8'hFE;
    expect_op(CALL, 3'd1, 8'hFE);
    step_check("rst_call", 1'b1, CALL, 3'd1);
    step_check("rst_call", 1'b0, CALL, 3'd1);
    sbq.delete();
    @(negedge clk); reset = 1'b1; step = 1'b1;
    @(negedge clk); reset = 1'b0; step = 1'b0;
    check_vec("rst_mid", '0, '0);
    @(negedge clk);
    check_vec("rst_mid_hold", '0, '0);

    run_op("pop_after_rst", POP, 3'd7, 8'hF5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
